// File: rtl/pipeline_pkg.sv
// Shared definitions for the RV32 pipeline stages: data width, writeback
// source select values and the memory-stage FSM encoding.
package pipeline_pkg;

    localparam int XLEN = 32;

    localparam logic RESULTSRC_ALU = 1'b0;
    localparam logic RESULTSRC_MEM = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for the memory stage; flags the cycle on which an
// outstanding access has used up its TIMEOUT_CYCLES budget.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic timeout_expire
);

    localparam logic [CNT_W-1:0] LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    // A zero budget disables the timeout; the counter may then wrap freely.
    always_comb begin
        timeout_expire = (TIMEOUT_CYCLES != 0) && en && (count == LAST);
    end

endmodule

// File: rtl/memory_cycle.sv
// RV32 memory stage: drives the req/ready data bus, stalls upstream while an
// access is outstanding, aborts timed-out accesses and holds the M/W register.
module memory_cycle
    import pipeline_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteM,
    input  logic            MemWriteM,
    input  logic            ResultSrcM,
    input  logic [4:0]      RD_M,
    input  logic [XLEN-1:0] PCPlus4M,
    input  logic [XLEN-1:0] WriteDataM,
    input  logic [XLEN-1:0] ALU_ResultM,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            StallM,
    output logic            RegWriteW,
    output logic            ResultSrcW,
    output logic [4:0]      RD_W,
    output logic [XLEN-1:0] PCPlus4W,
    output logic [XLEN-1:0] ALU_ResultW,
    output logic [XLEN-1:0] ReadDataW,
    output logic [XLEN-1:0] ResultW,
    output logic            mem_err
);

    mem_state_e      state, state_n;
    logic            access;
    logic            timer_clear;
    logic            timer_en;
    logic            timeout_expire;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic            we_q;

    assign access = MemWriteM | ResultSrcM;

    mem_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timer (
        .clk            (clk),
        .rst            (rst),
        .clear          (timer_clear),
        .en             (timer_en),
        .timeout_expire (timeout_expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // The IDLE request is combinational from the M inputs, so it is gated
    // with reset to keep the bus quiet while rst is held low.
    always_comb begin
        state_n     = state;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
        if (rst) begin
            case (state)
                IDLE: begin
                    if (access) begin
                        mem_req   = 1'b1;
                        mem_we    = MemWriteM;
                        mem_addr  = ALU_ResultM;
                        mem_wdata = WriteDataM;
                        if (!mem_ready) begin
                            state_n     = WAIT;
                            timer_clear = 1'b1;
                        end
                    end
                end
                WAIT: begin
                    mem_req   = 1'b1;
                    mem_we    = we_q;
                    mem_addr  = addr_q;
                    mem_wdata = wdata_q;
                    timer_en  = 1'b1;
                    if (mem_ready || timeout_expire) begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign StallM = mem_req & ~mem_ready & ~timeout_expire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else if (state == IDLE && access && !mem_ready) begin
            addr_q  <= ALU_ResultM;
            wdata_q <= WriteDataM;
            we_q    <= MemWriteM;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_err <= 1'b0;
        end else if (timeout_expire && !mem_ready) begin
            mem_err <= 1'b1;
        end
    end

    // When not stalled, any outstanding load has either completed or expired.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteW   <= 1'b0;
            ResultSrcW  <= 1'b0;
            RD_W        <= '0;
            PCPlus4W    <= '0;
            ALU_ResultW <= '0;
            ReadDataW   <= '0;
        end else if (StallM) begin
            RegWriteW <= 1'b0;
        end else begin
            RegWriteW   <= RegWriteM;
            ResultSrcW  <= ResultSrcM;
            RD_W        <= RD_M;
            PCPlus4W    <= PCPlus4M;
            ALU_ResultW <= ALU_ResultM;
            if (mem_req && !mem_we) begin
                if (mem_ready) begin
                    ReadDataW <= mem_rdata;
                end else if (timeout_expire) begin
                    ReadDataW <= '0;
                end
            end
        end
    end

    assign ResultW = (ResultSrcW == RESULTSRC_MEM) ? ReadDataW : ALU_ResultW;

endmodule
